bus_cycle_sequencer: RTL and testbench

- Downstream consumer of the address decoder.
- Once per CPU bus cycle it latches the address, R/W and the decoder outputs (ram_enable, io_enable, pia1/pia2/via/crtc enables, is_mirrored, is_readonly). It then runs a timed strobe sequence to the external SRAM or to the selected I/O chip.
- Applies display-RAM mirroring, suppresses writes to read-only (ROM) regions, and returns registered read data with a done pulse.

---
 rtl/bus_pkg.sv | 58 +++++
 rtl/bus_cycle_sequencer_if.sv | 45 ++++
 rtl/bus_cycle_sequencer_strobe_counter.sv | 27 ++
 rtl/bus_cycle_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_bus_cycle_sequencer.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/bus_pkg.sv
// Shared types and constants for the bus cycle sequencer: FSM states,
// latched cycle controls, mirroring and I/O select helpers.
package bus_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    ACCESS = 3'd2,
    HOLD   = 3'd3,
    DONE   = 3'd4
  } seq_state_t;

  localparam logic [16:0] MIRROR_MASK_DEFAULT = 17'h1F3FF;
  localparam logic [7:0]  UNMAPPED_READ_VALUE = 8'hFF;

  typedef struct packed {
    logic rw;
    logic ram_en;
    logic io_en;
    logic readonly;
  } cycle_ctl_t;

  function automatic logic [16:0] apply_mirror(input logic [16:0] addr,
                                               input logic        mirrored,
                                               input logic [16:0] mask);
    logic [16:0] result;
    if (mirrored) begin
      result = addr & mask;
    end else begin
      result = addr;
    end
    return result;
  endfunction

  // Returns {crtc, via, pia2, pia1}; a violated one-hot resolves to the highest priority chip.
  function automatic logic [3:0] select_io(input logic io_en,
                                           input logic pia1,
                                           input logic pia2,
                                           input logic via,
                                           input logic crtc);
    logic [3:0] sel;
    if (!io_en) begin
      sel = 4'b0000;
    end else if (pia1) begin
      sel = 4'b0001;
    end else if (pia2) begin
      sel = 4'b0010;
    end else if (via) begin
      sel = 4'b0100;
    end else if (crtc) begin
      sel = 4'b1000;
    end else begin
      sel = 4'b0000;
    end
    return sel;
  endfunction

endpackage

// File: rtl/bus_cycle_sequencer_if.sv
// Bus-side signal bundle between the decoder/timing logic (master) and the
// cycle sequencer (slave), including SRAM and I/O chip strobes.
interface bus_cycle_sequencer_if;
  logic        cycle_start;
  logic [16:0] addr;
  logic        rw;
  logic        ram_enable;
  logic        io_enable;
  logic        pia1_enable;
  logic        pia2_enable;
  logic        via_enable;
  logic        crtc_enable;
  logic        is_mirrored;
  logic        is_readonly;
  logic [7:0]  ram_data_in;
  logic [7:0]  io_data_in;
  logic [16:0] ram_addr;
  logic        ram_ce_n;
  logic        ram_oe_n;
  logic        ram_we_n;
  logic        pia1_cs;
  logic        pia2_cs;
  logic        via_cs;
  logic        crtc_cs;
  logic        io_strobe;
  logic [7:0]  rd_data;
  logic        busy;
  logic        done;
  logic        write_blocked;
  logic        overrun;

  modport master (
    output cycle_start, addr, rw, ram_enable, io_enable, pia1_enable, pia2_enable,
           via_enable, crtc_enable, is_mirrored, is_readonly, ram_data_in, io_data_in,
    input  ram_addr, ram_ce_n, ram_oe_n, ram_we_n, pia1_cs, pia2_cs, via_cs, crtc_cs,
           io_strobe, rd_data, busy, done, write_blocked, overrun
  );

  modport slave (
    input  cycle_start, addr, rw, ram_enable, io_enable, pia1_enable, pia2_enable,
           via_enable, crtc_enable, is_mirrored, is_readonly, ram_data_in, io_data_in,
    output ram_addr, ram_ce_n, ram_oe_n, ram_we_n, pia1_cs, pia2_cs, via_cs, crtc_cs,
           io_strobe, rd_data, busy, done, write_blocked, overrun
  );
endinterface

// File: rtl/bus_cycle_sequencer_strobe_counter.sv
// 4-bit loadable down-counter timing the ACCESS and HOLD phases; tc flags
// the last clock of the loaded interval.
module strobe_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_value,
  input  logic       dec,
  output logic       tc
);
  logic [3:0] count_r;

  // Load has priority over decrement; the count parks at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= 4'd0;
    end else if (load) begin
      count_r <= load_value;
    end else if (dec && (count_r != 4'd0)) begin
      count_r <= count_r - 4'd1;
    end else begin
      count_r <= count_r;
    end
  end

  assign tc = (count_r == 4'd1);
endmodule

// File: rtl/bus_cycle_sequencer.sv
// Per-bus-cycle sequencer: latches address and decoder outputs on cycle_start,
// then drives timed SRAM or I/O strobes and returns registered read data.
module bus_cycle_sequencer
  import bus_pkg::*;
#(
  parameter int          RAM_CYCLES  = 2,
  parameter int          IO_CYCLES   = 4,
  parameter int          HOLD_CYCLES = 1,
  parameter logic [16:0] MIRROR_MASK = MIRROR_MASK_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  bus_cycle_sequencer_if.slave  bus
);
  localparam logic HOLD_EN = (HOLD_CYCLES > 0);

  seq_state_t  state_r;
  cycle_ctl_t  ctl_r;
  logic [16:0] ram_addr_r;
  logic        ram_ce_n_r;
  logic        ram_oe_n_r;
  logic        ram_we_n_r;
  logic [3:0]  cs_r;
  logic        io_strobe_r;
  logic [7:0]  rd_data_r;
  logic        busy_r;
  logic        done_r;
  logic        write_blocked_r;
  logic        overrun_r;
  logic        cnt_load_s;
  logic [3:0]  cnt_value_s;
  logic        cnt_dec_s;
  logic        cnt_tc_s;

  // Counter load: access length on leaving SETUP, hold length on leaving ACCESS.
  always_comb begin
    cnt_load_s  = 1'b0;
    cnt_value_s = 4'd0;
    case (state_r)
      SETUP: begin
        cnt_load_s = 1'b1;
        if (ctl_r.io_en) begin
          cnt_value_s = 4'(IO_CYCLES);
        end else begin
          cnt_value_s = 4'(RAM_CYCLES);
        end
      end
      ACCESS: begin
        if (cnt_tc_s && HOLD_EN) begin
          cnt_load_s  = 1'b1;
          cnt_value_s = 4'(HOLD_CYCLES);
        end else begin
          cnt_load_s  = 1'b0;
        end
      end
      default: begin
        cnt_load_s  = 1'b0;
      end
    endcase
  end

  assign cnt_dec_s = (state_r == ACCESS) || (state_r == HOLD);

  strobe_counter u_counter (
    .clk        (clk),
    .reset      (reset),
    .load       (cnt_load_s),
    .load_value (cnt_value_s),
    .dec        (cnt_dec_s),
    .tc         (cnt_tc_s)
  );

  // Sequencer FSM; outputs are registered with the value for the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r         <= IDLE;
      ctl_r           <= '0;
      ram_addr_r      <= 17'd0;
      ram_ce_n_r      <= 1'b1;
      ram_oe_n_r      <= 1'b1;
      ram_we_n_r      <= 1'b1;
      cs_r            <= 4'b0000;
      io_strobe_r     <= 1'b0;
      rd_data_r       <= UNMAPPED_READ_VALUE;
      busy_r          <= 1'b0;
      done_r          <= 1'b0;
      write_blocked_r <= 1'b0;
      overrun_r       <= 1'b0;
    end else begin
      overrun_r <= (state_r != IDLE) && bus.cycle_start;
      case (state_r)
        IDLE: begin
          done_r          <= 1'b0;
          write_blocked_r <= 1'b0;
          if (bus.cycle_start) begin
            ctl_r.rw       <= bus.rw;
            ctl_r.ram_en   <= bus.ram_enable;
            ctl_r.io_en    <= bus.io_enable;
            ctl_r.readonly <= bus.is_readonly;
            ram_addr_r     <= apply_mirror(bus.addr, bus.is_mirrored, MIRROR_MASK);
            ram_ce_n_r     <= ~bus.ram_enable;
            cs_r           <= select_io(bus.io_enable, bus.pia1_enable, bus.pia2_enable,
                                        bus.via_enable, bus.crtc_enable);
            busy_r         <= 1'b1;
            state_r        <= SETUP;
          end else begin
            state_r        <= IDLE;
          end
        end
        SETUP: begin
          if (ctl_r.ram_en) begin
            if (ctl_r.rw) begin
              ram_oe_n_r      <= 1'b0;
            end else if (ctl_r.readonly) begin
              write_blocked_r <= 1'b1;
            end else begin
              ram_we_n_r      <= 1'b0;
            end
          end else begin
            ram_oe_n_r <= 1'b1;
          end
          io_strobe_r <= ctl_r.io_en;
          state_r     <= ACCESS;
        end
        ACCESS: begin
          write_blocked_r <= 1'b0;
          if (cnt_tc_s) begin
            ram_oe_n_r  <= 1'b1;
            ram_we_n_r  <= 1'b1;
            io_strobe_r <= 1'b0;
            if (ctl_r.rw) begin
              if (ctl_r.ram_en) begin
                rd_data_r <= bus.ram_data_in;
              end else if (ctl_r.io_en) begin
                rd_data_r <= bus.io_data_in;
              end else begin
                rd_data_r <= UNMAPPED_READ_VALUE;
              end
            end else begin
              rd_data_r <= rd_data_r;
            end
            if (HOLD_EN) begin
              state_r <= HOLD;
            end else begin
              ram_ce_n_r <= 1'b1;
              cs_r       <= 4'b0000;
              done_r     <= 1'b1;
              busy_r     <= 1'b0;
              state_r    <= DONE;
            end
          end else begin
            state_r <= ACCESS;
          end
        end
        HOLD: begin
          if (cnt_tc_s) begin
            ram_ce_n_r <= 1'b1;
            cs_r       <= 4'b0000;
            done_r     <= 1'b1;
            busy_r     <= 1'b0;
            state_r    <= DONE;
          end else begin
            state_r    <= HOLD;
          end
        end
        DONE: begin
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.ram_addr      = ram_addr_r;
  assign bus.ram_ce_n      = ram_ce_n_r;
  assign bus.ram_oe_n      = ram_oe_n_r;
  assign bus.ram_we_n      = ram_we_n_r;
  assign bus.pia1_cs       = cs_r[0];
  assign bus.pia2_cs       = cs_r[1];
  assign bus.via_cs        = cs_r[2];
  assign bus.crtc_cs       = cs_r[3];
  assign bus.io_strobe     = io_strobe_r;
  assign bus.rd_data       = rd_data_r;
  assign bus.busy          = busy_r;
  assign bus.done          = done_r;
  assign bus.write_blocked = write_blocked_r;
  assign bus.overrun       = overrun_r;
endmodule

// File: tb/tb_bus_cycle_sequencer.sv
// Directed bench for bus_cycle_sequencer: drives one bus cycle at a time and
// tallies strobe activity per cycle window against hand-computed expectations.
module tb_bus_cycle_sequencer;
  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  bus_cycle_sequencer_if bus_if ();

  bus_cycle_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  int n_checks = 0;
  int n_fail   = 0;

  int oe_cnt, oe_first, we_cnt, stb_cnt, stb_first, ce_cnt;
  int wb_cnt, wb_at, done_cnt, done_at, ov_cnt, addr_bad;
  int cs_cnt [4];
  logic [16:0] exp_addr;

  task automatic check_eq(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic start_cycle(input logic [16:0] a, input logic r, input logic ram_en,
                             input logic io_en, input logic [3:0] chip, input logic mir,
                             input logic ro);
    bus_if.addr        = a;
    bus_if.rw          = r;
    bus_if.ram_enable  = ram_en;
    bus_if.io_enable   = io_en;
    bus_if.pia1_enable = chip[0];
    bus_if.pia2_enable = chip[1];
    bus_if.via_enable  = chip[2];
    bus_if.crtc_enable = chip[3];
    bus_if.is_mirrored = mir;
    bus_if.is_readonly = ro;
    bus_if.cycle_start = 1'b1;
    @(negedge clk);
    bus_if.cycle_start = 1'b0;
    // Scramble the sampled inputs: the sequencer must have latched them already.
    bus_if.addr        = ~a;
    bus_if.rw          = ~r;
    bus_if.ram_enable  = ~ram_en;
    bus_if.io_enable   = ~io_en;
    bus_if.is_mirrored = ~mir;
    bus_if.is_readonly = ~ro;
  endtask

  task automatic observe(input int ncyc, input int inject_at);
    oe_cnt = 0; oe_first = -1; we_cnt = 0; stb_cnt = 0; stb_first = -1; ce_cnt = 0;
    wb_cnt = 0; wb_at = -1; done_cnt = 0; done_at = -1; ov_cnt = 0; addr_bad = 0;
    for (int i = 0; i < 4; i++) cs_cnt[i] = 0;
    for (int k = 0; k < ncyc; k++) begin
      if (!bus_if.ram_oe_n) begin
        oe_cnt++;
        if (oe_first < 0) oe_first = k;
      end
      if (!bus_if.ram_we_n) we_cnt++;
      if (bus_if.io_strobe) begin
        stb_cnt++;
        if (stb_first < 0) stb_first = k;
      end
      if (!bus_if.ram_ce_n) ce_cnt++;
      if (bus_if.write_blocked) begin
        wb_cnt++;
        if (wb_at < 0) wb_at = k;
      end
      if (bus_if.done) begin
        done_cnt++;
        if (done_at < 0) done_at = k;
      end
      if (bus_if.overrun) ov_cnt++;
      if ((!bus_if.ram_ce_n || bus_if.busy) && (bus_if.ram_addr !== exp_addr)) addr_bad++;
      if (bus_if.pia1_cs) cs_cnt[0]++;
      if (bus_if.pia2_cs) cs_cnt[1]++;
      if (bus_if.via_cs)  cs_cnt[2]++;
      if (bus_if.crtc_cs) cs_cnt[3]++;
      bus_if.cycle_start = (k == inject_at);
      @(negedge clk);
    end
    bus_if.cycle_start = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus_if.cycle_start = 1'b0;
    bus_if.addr = 17'd0;
    bus_if.rw = 1'b0;
    bus_if.ram_enable = 1'b0;
    bus_if.io_enable = 1'b0;
    bus_if.pia1_enable = 1'b0;
    bus_if.pia2_enable = 1'b0;
    bus_if.via_enable = 1'b0;
    bus_if.crtc_enable = 1'b0;
    bus_if.is_mirrored = 1'b0;
    bus_if.is_readonly = 1'b0;
    bus_if.ram_data_in = 8'h00;
    bus_if.io_data_in = 8'h00;
    repeat (2) @(negedge clk);

    check_eq("rst_ram_addr", 32'(bus_if.ram_addr), 32'h0);
    check_eq("rst_ram_ctl", 32'({bus_if.ram_ce_n, bus_if.ram_oe_n, bus_if.ram_we_n}), 32'h7);
    check_eq("rst_cs", 32'({bus_if.crtc_cs, bus_if.via_cs, bus_if.pia2_cs, bus_if.pia1_cs}), 32'h0);
    check_eq("rst_rd_data", 32'(bus_if.rd_data), 32'hFF);
    check_eq("rst_flags", 32'({bus_if.io_strobe, bus_if.busy, bus_if.done,
                              bus_if.write_blocked, bus_if.overrun}), 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // RAM read
    bus_if.ram_data_in = 8'hA5;
    exp_addr = 17'h01234;
    start_cycle(17'h01234, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
    check_eq("rd_busy_setup", 32'(bus_if.busy), 32'h1);
    check_eq("rd_ce_setup", 32'(bus_if.ram_ce_n), 32'h0);
    check_eq("rd_oe_setup", 32'(bus_if.ram_oe_n), 32'h1);
    observe(8, -1);
    check_eq("rd_ce_cnt", 32'(ce_cnt), 32'd4);
    check_eq("rd_oe_cnt", 32'(oe_cnt), 32'd2);
    check_eq("rd_oe_first", 32'(oe_first), 32'd1);
    check_eq("rd_we_cnt", 32'(we_cnt), 32'd0);
    check_eq("rd_done_cnt", 32'(done_cnt), 32'd1);
    check_eq("rd_done_at", 32'(done_at), 32'd4);
    check_eq("rd_addr_bad", 32'(addr_bad), 32'd0);
    check_eq("rd_data", 32'(bus_if.rd_data), 32'hA5);
    check_eq("rd_busy_end", 32'(bus_if.busy), 32'h0);

    // ROM write is suppressed
    exp_addr = 17'h0C000;
    start_cycle(17'h0C000, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1);
    observe(8, -1);
    check_eq("rom_we_cnt", 32'(we_cnt), 32'd0);
    check_eq("rom_wb_cnt", 32'(wb_cnt), 32'd1);
    check_eq("rom_wb_at", 32'(wb_at), 32'd1);
    check_eq("rom_done_at", 32'(done_at), 32'd4);
    check_eq("rom_rd_keep", 32'(bus_if.rd_data), 32'hA5);

    // Mirrored write
    exp_addr = 17'h08021;
    start_cycle(17'h08C21, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0);
    observe(8, -1);
    check_eq("mir_we_cnt", 32'(we_cnt), 32'd2);
    check_eq("mir_wb_cnt", 32'(wb_cnt), 32'd0);
    check_eq("mir_addr_bad", 32'(addr_bad), 32'd0);
    check_eq("mir_addr", 32'(bus_if.ram_addr), 32'h08021);
    check_eq("mir_done_at", 32'(done_at), 32'd4);

    // I/O read from PIA1
    bus_if.io_data_in = 8'h3C;
    exp_addr = 17'h0E812;
    start_cycle(17'h0E812, 1'b1, 1'b0, 1'b1, 4'b0001, 1'b0, 1'b0);
    observe(10, -1);
    check_eq("io_pia1_cnt", 32'(cs_cnt[0]), 32'd6);
    check_eq("io_other_cs", 32'(cs_cnt[1] + cs_cnt[2] + cs_cnt[3]), 32'd0);
    check_eq("io_stb_cnt", 32'(stb_cnt), 32'd4);
    check_eq("io_stb_first", 32'(stb_first), 32'd1);
    check_eq("io_ce_cnt", 32'(ce_cnt), 32'd0);
    check_eq("io_done_at", 32'(done_at), 32'd6);
    check_eq("io_rd_data", 32'(bus_if.rd_data), 32'h3C);

    // Unmapped read with an overlapping cycle_start
    exp_addr = 17'h0E805;
    start_cycle(17'h0E805, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
    observe(10, 1);
    check_eq("um_strobes", 32'(oe_cnt + we_cnt + stb_cnt + ce_cnt), 32'd0);
    check_eq("um_cs", 32'(cs_cnt[0] + cs_cnt[1] + cs_cnt[2] + cs_cnt[3]), 32'd0);
    check_eq("um_rd_data", 32'(bus_if.rd_data), 32'hFF);
    check_eq("um_overrun", 32'(ov_cnt), 32'd1);
    check_eq("um_done_cnt", 32'(done_cnt), 32'd1);
    check_eq("um_done_at", 32'(done_at), 32'd4);

    // Reset during ACCESS of a RAM write
    exp_addr = 17'h00100;
    start_cycle(17'h00100, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
    observe(2, -1);
    check_eq("rst_mid_we_seen", 32'(we_cnt), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_eq("rst_mid_ram_ctl", 32'({bus_if.ram_ce_n, bus_if.ram_oe_n, bus_if.ram_we_n}), 32'h7);
    check_eq("rst_mid_busy", 32'(bus_if.busy), 32'h0);
    check_eq("rst_mid_rd_data", 32'(bus_if.rd_data), 32'hFF);
    exp_addr = 17'h0;
    observe(8, -1);
    check_eq("rst_mid_no_done", 32'(done_cnt), 32'd0);
    check_eq("rst_mid_no_we", 32'(we_cnt), 32'd0);

    // A following cycle completes normally
    bus_if.ram_data_in = 8'h5A;
    exp_addr = 17'h00200;
    start_cycle(17'h00200, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
    observe(8, -1);
    check_eq("post_done_at", 32'(done_at), 32'd4);
    check_eq("post_oe_cnt", 32'(oe_cnt), 32'd2);
    check_eq("post_rd_data", 32'(bus_if.rd_data), 32'h5A);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
